pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port stall_data  input  1  GPR Tuse/Tnew hazard request for the ID instruction.
REQ-004 SHALL have port mdu_use_D  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-005 SHALL have port mdu_start  input  1  EX instruction starts a multiply/divide.
REQ-006 SHALL have port mdu_is_div  input  1  qualifies mdu_start: 1 = div/divu, 0 = mult/multu.
REQ-007 SHALL have ports mem_req and mem_ack  input  1 each  MEM-stage load/store request and bus completion.
REQ-008 SHALL have port exc_req  input  1  interrupt/exception request from CP0.
REQ-009 SHALL have port eret_D  input  1  ID instruction is eret.
REQ-010 SHALL have outputs pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop, ex_mem_we, mem_wb_we  output  1 each  pipeline register controls.
REQ-011 SHALL have outputs flush  output  1  (drives intExcReq of the ID/EX, EX/MEM and MEM/WB registers), mdu_busy  output  1, and state  output  2  (current FSM state).

Function
REQ-012 SHALL hold a 2-bit FSM: RUN=0, BUS_WAIT=2, EXC=3; value 1 is reserved and never entered.
REQ-013 SHALL hold a 4-bit MDU counter, cnt, and SHALL drive mdu_busy = (cnt != 0).
REQ-014 SHALL load cnt with 5 (mult) or 10 (div) on a cycle where mdu_start=1, ex_mem_we=1 and flush=0.
REQ-015 SHALL otherwise decrement a nonzero cnt by 1 every cycle, including frozen cycles, and SHALL saturate cnt at 0.
REQ-016 SHALL compute stall = stall_data | (mdu_use_D & (mdu_busy | mdu_start)).
REQ-017 Priority order SHALL be: reset > exc_req > bus wait > stall > eret_D.
REQ-018 On exc_req=1, SHALL drive flush=1 and all *_we=1, with if_id_nop=0 and id_ex_nop=0.
REQ-019 On exc_req=1, the next state SHALL be EXC, and this SHALL override BUS_WAIT and stall.
REQ-020 In EXC, for exactly one cycle, SHALL advance all stages with stall and eret_D ignored, then return to RUN.
REQ-021 Bus wait is the condition (state==RUN & mem_req & !mem_ack) | (state==BUS_WAIT & !mem_ack).
REQ-022 During bus wait, SHALL drive all *_we=0 and both nops=0 (full freeze); state SHALL be BUS_WAIT.
REQ-023 SHALL leave BUS_WAIT the cycle mem_ack=1: all stages advance that cycle, and the next state is RUN.
REQ-024 On stall in RUN, SHALL drive pc_we=0, if_id_we=0, id_ex_we=1, id_ex_nop=1 (bubble), ex_mem_we=1, mem_wb_we=1.
REQ-025 On eret_D with no higher-priority event, SHALL drive all *_we=1 and if_id_nop=1 (kill delay-slot fetch).
REQ-026 Otherwise SHALL drive all *_we=1, both nops=0 and flush=0.
REQ-027 All outputs except state and mdu_busy SHALL be combinational from the inputs, state and cnt, with zero latency.

Reset
REQ-028 While reset=1, SHALL drive all *_we=0, both nops=0 and flush=0.
REQ-029 The reset edge SHALL set state=RUN and cnt=0 (mdu_busy=0), and SHALL abort any bus wait or MDU count mid-operation.
REQ-030 SHALL show state=RUN, mdu_busy=0 and normal advance on the first cycle after reset deasserts.

Configuration
REQ-031 With macro PIPE_CTRL_BUS_WAIT_EN defined, SHALL implement REQ-021..REQ-023.
REQ-032 Without PIPE_CTRL_BUS_WAIT_EN, SHALL ignore mem_req and mem_ack, never enter BUS_WAIT, and have no freeze cycles.

Verification
REQ-033 mult in EX (mdu_start=1, mdu_is_div=0), then mflo in ID:
  - stall for the start cycle plus 5 busy cycles (pc_we=0, id_ex_nop=1);
  - mdu_busy falls after exactly 5 cycles.
REQ-034 div start, then an unrelated instruction -> no stall; mdu_busy=1 for 10 cycles; cnt reaches 0 and stays.
REQ-035 With PIPE_CTRL_BUS_WAIT_EN: mem_req=1, mem_ack low for 3 cycles ->
  - state=2 and all *_we=0 for 3 cycles;
  - ack cycle advances; state=0 next.
REQ-036 exc_req=1 during BUS_WAIT with a stall pending -> flush=1 and all *_we=1 that cycle; state=3 next, then 0.
REQ-037 exc_req=1 coinciding with mdu_start=1 -> cnt not loaded; mdu_busy stays 0.
REQ-038 reset=1 for 1 cycle in the middle of a div count -> mdu_busy=0 and state=0 on the following cycle.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_ctrl.
// slave = controller side, master = datapath side.
interface pipe_ctrl_if;
   logic       stall_data;
   logic       mdu_use_D;
   logic       mdu_start;
   logic       mdu_is_div;
   logic       mem_req;
   logic       mem_ack;
   logic       exc_req;
   logic       eret_D;
   logic       pc_we;
   logic       if_id_we;
   logic       if_id_nop;
   logic       id_ex_we;
   logic       id_ex_nop;
   logic       ex_mem_we;
   logic       mem_wb_we;
   logic       flush;
   logic       mdu_busy;
   logic [1:0] state;

   modport slave (
      input  stall_data, mdu_use_D, mdu_start, mdu_is_div,
             mem_req, mem_ack, exc_req, eret_D,
      output pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop,
             ex_mem_we, mem_wb_we, flush, mdu_busy, state
   );

   modport master (
      output stall_data, mdu_use_D, mdu_start, mdu_is_div,
             mem_req, mem_ack, exc_req, eret_D,
      input  pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop,
             ex_mem_we, mem_wb_we, flush, mdu_busy, state
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: exception flush, bus-wait freeze, hazard/MDU stall, eret kill.
// Define PIPE_CTRL_BUS_WAIT_EN to enable the MEM-stage bus-wait freeze (BUS_WAIT state).
module pipe_ctrl (
   input  logic        clk,
   input  logic        reset,
   pipe_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      BUS_WAIT = 2'd2,
      EXC      = 2'd3
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic mdu_busy;
   logic stall;
   logic bus_wait;
   logic pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop, ex_mem_we, mem_wb_we, flush;

   assign mdu_busy = (cnt_q != 4'd0);
   assign stall    = bus.stall_data | (bus.mdu_use_D & (mdu_busy | bus.mdu_start));

`ifdef PIPE_CTRL_BUS_WAIT_EN
   assign bus_wait = ((state_q == RUN) & bus.mem_req & ~bus.mem_ack) |
                     ((state_q == BUS_WAIT) & ~bus.mem_ack);
`else
   logic unused_bus;
   assign unused_bus = bus.mem_req ^ bus.mem_ack;
   assign bus_wait   = 1'b0;
`endif

   always_comb begin
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      if_id_nop = 1'b0;
      id_ex_we  = 1'b1;
      id_ex_nop = 1'b0;
      ex_mem_we = 1'b1;
      mem_wb_we = 1'b1;
      flush     = 1'b0;
      if (reset) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         id_ex_we  = 1'b0;
         ex_mem_we = 1'b0;
         mem_wb_we = 1'b0;
      end else if (bus.exc_req) begin
         flush = 1'b1;
      end else if (state_q == EXC) begin
         // Post-exception cycle: plain advance, stall and eret deliberately ignored.
         flush = 1'b0;
      end else if (bus_wait) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         id_ex_we  = 1'b0;
         ex_mem_we = 1'b0;
         mem_wb_we = 1'b0;
      end else if ((state_q == RUN) && stall) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         id_ex_nop = 1'b1;
      end else if (bus.eret_D) begin
         if_id_nop = 1'b1;
      end
   end

   always_comb begin
      state_d = RUN;
      if (bus.exc_req) begin
         state_d = EXC;
      end else if (bus_wait) begin
         state_d = BUS_WAIT;
      end
   end

   // The MDU only starts when its instruction actually leaves EX; otherwise it keeps counting down.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.mdu_start && ex_mem_we && !flush) begin
         cnt_d = bus.mdu_is_div ? 4'd10 : 4'd5;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.pc_we     = pc_we;
   assign bus.if_id_we  = if_id_we;
   assign bus.if_id_nop = if_id_nop;
   assign bus.id_ex_we  = id_ex_we;
   assign bus.id_ex_nop = id_ex_nop;
   assign bus.ex_mem_we = ex_mem_we;
   assign bus.mem_wb_we = mem_wb_we;
   assign bus.flush     = flush;
   assign bus.mdu_busy  = mdu_busy;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized run against a reference model.
module tb_pipe_ctrl;

   logic clk;
   logic reset;
   pipe_ctrl_if bus ();

   pipe_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop, ex_mem_we, mem_wb_we, flush}
   localparam logic [7:0] RST_V  = 8'b0000_0000;
   localparam logic [7:0] FRZ_V  = 8'b0000_0000;
   localparam logic [7:0] ADV_V  = 8'b1101_0110;
   localparam logic [7:0] STL_V  = 8'b0001_1110;
   localparam logic [7:0] ERET_V = 8'b1111_0110;
   localparam logic [7:0] EXC_V  = 8'b1101_0111;

   logic [7:0] ctl;
   assign ctl = {bus.pc_we, bus.if_id_we, bus.if_id_nop, bus.id_ex_we,
                 bus.id_ex_nop, bus.ex_mem_we, bus.mem_wb_we, bus.flush};

   int errors = 0;
   int checks = 0;

   // Reference model: state as 0/2/3 and MDU remaining-cycle count.
   int m_state = 0;
   int m_cnt   = 0;

   function automatic bit m_waiting();
`ifdef PIPE_CTRL_BUS_WAIT_EN
      if (m_state == 0 && bus.mem_req && !bus.mem_ack) return 1'b1;
      if (m_state == 2 && !bus.mem_ack) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic bit m_stall();
      return bus.stall_data || (bus.mdu_use_D && (m_cnt > 0 || bus.mdu_start));
   endfunction

   function automatic logic [7:0] m_ctl();
      if (reset)                    return RST_V;
      if (bus.exc_req)              return EXC_V;
      if (m_state == 3)             return ADV_V;
      if (m_waiting())              return FRZ_V;
      if (m_state == 0 && m_stall()) return STL_V;
      if (bus.eret_D)               return ERET_V;
      return ADV_V;
   endfunction

   task automatic m_update();
      logic [7:0] c;
      bit w;
      c = m_ctl();
      w = m_waiting();
      if (reset) begin
         m_state = 0;
         m_cnt   = 0;
      end else begin
         m_state = bus.exc_req ? 3 : (w ? 2 : 0);
         if (bus.mdu_start && c[2] && !c[0]) m_cnt = bus.mdu_is_div ? 10 : 5;
         else if (m_cnt > 0)                 m_cnt = m_cnt - 1;
      end
   endtask

   task automatic tick();
      m_update();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      reset          = 1'b0;
      bus.stall_data = 1'b0;
      bus.mdu_use_D  = 1'b0;
      bus.mdu_start  = 1'b0;
      bus.mdu_is_div = 1'b0;
      bus.mem_req    = 1'b0;
      bus.mem_ack    = 1'b0;
      bus.exc_req    = 1'b0;
      bus.eret_D     = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset         = 1'b1;
      bus.exc_req   = 1'b1;
      bus.eret_D    = 1'b1;
      bus.mdu_start = 1'b1;
      settle();
      checks++;
      if (ctl !== RST_V) begin errors++; $display("FAIL reset_ctl: got=%b exp=%b", ctl, RST_V); end
      tick();
      settle();
      checks++;
      if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state: got=%0d exp=0", bus.state); end
      checks++;
      if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got=%b exp=0", bus.mdu_busy); end
      tick();
      idle();
      settle();
      checks++;
      if (ctl !== ADV_V || bus.state !== 2'd0 || bus.mdu_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ctl=%b st=%0d busy=%b exp ctl=%b st=0 busy=0", ctl, bus.state, bus.mdu_busy, ADV_V);
      end
      tick();
   endtask

   task automatic test_mult_stall();
      idle();
      bus.mdu_start  = 1'b1;
      bus.mdu_is_div = 1'b0;
      bus.mdu_use_D  = 1'b1;
      settle();
      checks++;
      if (ctl !== STL_V || bus.mdu_busy !== 1'b0) begin
         errors++; $display("FAIL mult_start: ctl=%b busy=%b exp ctl=%b busy=0", ctl, bus.mdu_busy, STL_V);
      end
      tick();
      bus.mdu_start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         settle();
         checks++;
         if (ctl !== STL_V || bus.mdu_busy !== 1'b1) begin
            errors++; $display("FAIL mult_busy[%0d]: ctl=%b busy=%b exp ctl=%b busy=1", i, ctl, bus.mdu_busy, STL_V);
         end
         tick();
      end
      settle();
      checks++;
      if (ctl !== ADV_V || bus.mdu_busy !== 1'b0) begin
         errors++; $display("FAIL mult_done: ctl=%b busy=%b exp ctl=%b busy=0", ctl, bus.mdu_busy, ADV_V);
      end
      tick();
      idle();
   endtask

   task automatic test_div_no_stall();
      idle();
      bus.mdu_start  = 1'b1;
      bus.mdu_is_div = 1'b1;
      settle();
      checks++;
      if (ctl !== ADV_V) begin errors++; $display("FAIL div_start: ctl=%b exp=%b", ctl, ADV_V); end
      tick();
      idle();
      for (int i = 1; i <= 10; i++) begin
         settle();
         checks++;
         if (ctl !== ADV_V || bus.mdu_busy !== 1'b1) begin
            errors++; $display("FAIL div_busy[%0d]: ctl=%b busy=%b exp ctl=%b busy=1", i, ctl, bus.mdu_busy, ADV_V);
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++;
         if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL div_idle[%0d]: busy=%b exp=0", i, bus.mdu_busy); end
         tick();
      end
   endtask

   task automatic test_bus_wait();
      idle();
      bus.mem_req = 1'b1;
`ifdef PIPE_CTRL_BUS_WAIT_EN
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++;
         if (ctl !== FRZ_V || bus.state !== ((i == 0) ? 2'd0 : 2'd2)) begin
            errors++; $display("FAIL bus_freeze[%0d]: ctl=%b st=%0d exp ctl=%b", i, ctl, bus.state, FRZ_V);
         end
         tick();
      end
      bus.mem_ack = 1'b1;
      settle();
      checks++;
      if (ctl !== ADV_V || bus.state !== 2'd2) begin
         errors++; $display("FAIL bus_ack: ctl=%b st=%0d exp ctl=%b st=2", ctl, bus.state, ADV_V);
      end
      tick();
      idle();
      settle();
      checks++;
      if (bus.state !== 2'd0) begin errors++; $display("FAIL bus_exit: st=%0d exp=0", bus.state); end
      tick();
`else
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++;
         if (ctl !== ADV_V || bus.state !== 2'd0) begin
            errors++; $display("FAIL bus_ignored[%0d]: ctl=%b st=%0d exp ctl=%b st=0", i, ctl, bus.state, ADV_V);
         end
         tick();
      end
      idle();
`endif
   endtask

   task automatic test_exc_override();
      idle();
`ifdef PIPE_CTRL_BUS_WAIT_EN
      bus.mem_req = 1'b1;
      tick();
`endif
      bus.exc_req    = 1'b1;
      bus.stall_data = 1'b1;
      settle();
      checks++;
      if (ctl !== EXC_V) begin errors++; $display("FAIL exc_cycle: ctl=%b exp=%b", ctl, EXC_V); end
      tick();
      idle();
      bus.stall_data = 1'b1;
      bus.eret_D     = 1'b1;
      settle();
      checks++;
      if (ctl !== ADV_V || bus.state !== 2'd3) begin
         errors++; $display("FAIL exc_state: ctl=%b st=%0d exp ctl=%b st=3", ctl, bus.state, ADV_V);
      end
      tick();
      settle();
      checks++;
      if (ctl !== STL_V || bus.state !== 2'd0) begin
         errors++; $display("FAIL exc_return: ctl=%b st=%0d exp ctl=%b st=0", ctl, bus.state, STL_V);
      end
      tick();
      idle();
   endtask

   task automatic test_exc_mdu();
      idle();
      bus.exc_req   = 1'b1;
      bus.mdu_start = 1'b1;
      bus.mdu_is_div = 1'b1;
      settle();
      checks++;
      if (ctl !== EXC_V) begin errors++; $display("FAIL exc_mdu_ctl: ctl=%b exp=%b", ctl, EXC_V); end
      tick();
      idle();
      settle();
      checks++;
      if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL exc_mdu_busy: busy=%b exp=0", bus.mdu_busy); end
      tick();
   endtask

   task automatic test_eret();
      idle();
      bus.eret_D = 1'b1;
      settle();
      checks++;
      if (ctl !== ERET_V) begin errors++; $display("FAIL eret_kill: ctl=%b exp=%b", ctl, ERET_V); end
      bus.stall_data = 1'b1;
      settle();
      checks++;
      if (ctl !== STL_V) begin errors++; $display("FAIL eret_stall: ctl=%b exp=%b", ctl, STL_V); end
      tick();
      idle();
   endtask

   task automatic test_reset_mid_div();
      idle();
      bus.mdu_start  = 1'b1;
      bus.mdu_is_div = 1'b1;
      tick();
      idle();
      tick();
      tick();
      settle();
      checks++;
      if (bus.mdu_busy !== 1'b1) begin errors++; $display("FAIL div_pre_reset: busy=%b exp=1", bus.mdu_busy); end
      reset = 1'b1;
      settle();
      checks++;
      if (ctl !== RST_V) begin errors++; $display("FAIL mid_reset_ctl: ctl=%b exp=%b", ctl, RST_V); end
      tick();
      reset = 1'b0;
      settle();
      checks++;
      if (bus.mdu_busy !== 1'b0 || bus.state !== 2'd0 || ctl !== ADV_V) begin
         errors++; $display("FAIL mid_reset_after: busy=%b st=%0d ctl=%b exp busy=0 st=0 ctl=%b", bus.mdu_busy, bus.state, ctl, ADV_V);
      end
      tick();
   endtask

   task automatic test_random();
      logic [7:0] e;
      for (int n = 0; n < 600; n++) begin
         reset          = ($urandom_range(63) == 0);
         bus.exc_req    = ($urandom_range(15) == 0);
         bus.stall_data = ($urandom_range(7) == 0);
         bus.mdu_use_D  = ($urandom_range(2) == 0);
         bus.mdu_start  = ($urandom_range(5) == 0);
         bus.mdu_is_div = 1'($urandom_range(1));
         bus.mem_req    = ($urandom_range(3) == 0);
         bus.mem_ack    = 1'($urandom_range(1));
         bus.eret_D     = ($urandom_range(7) == 0);
         settle();
         e = m_ctl();
         checks++;
         if (ctl !== e) begin errors++; $display("FAIL rand_ctl[%0d]: got=%b exp=%b", n, ctl, e); end
         checks++;
         if (bus.state !== 2'(m_state)) begin errors++; $display("FAIL rand_state[%0d]: got=%0d exp=%0d", n, bus.state, m_state); end
         checks++;
         if (bus.mdu_busy !== (m_cnt != 0)) begin errors++; $display("FAIL rand_busy[%0d]: got=%b exp=%b", n, bus.mdu_busy, (m_cnt != 0)); end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      test_mult_stall();
      test_div_no_stall();
      test_bus_wait();
      test_exc_override();
      test_exc_mdu();
      test_eret();
      test_reset_mid_div();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
